// File: rtl/deser_frame_ctrl_pkg.sv
// Shared types and width helpers for the deserialiser frame controller.
package deser_pkg;

  typedef enum logic [1:0] {IDLE, RECV, SEND} deser_state_t;

  // A single-register bank still needs a one-bit index.
  function automatic int unsigned sel_width(int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  function automatic int unsigned len_width(int unsigned nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/deser_frame_ctrl_if.sv
// Word-in / frame-out handshake and register-bank control signals.
interface deser_frame_ctrl_if #(
  parameter int unsigned NREGS = 2
);
  import deser_pkg::*;

  localparam int unsigned SELW = sel_width(NREGS);
  localparam int unsigned LENW = len_width(NREGS);

  logic             recv_val;
  logic             recv_rdy;
  logic [LENW-1:0]  cfg_len;
  logic [NREGS-1:0] wr_en;
  logic [SELW-1:0]  wr_sel;
  logic             send_val;
  logic             send_rdy;
  logic [LENW-1:0]  frame_len;
  logic             busy;

  modport master (
    input  recv_val, cfg_len, send_rdy,
    output recv_rdy, wr_en, wr_sel, send_val, frame_len, busy
  );

  modport slave (
    output recv_val, cfg_len, send_rdy,
    input  recv_rdy, wr_en, wr_sel, send_val, frame_len, busy
  );

endinterface

// File: rtl/deser_frame_ctrl_onehot_dec.sv
// Slot index to one-hot write enable, forced to zero when not enabled.
module onehot_dec #(
  parameter int unsigned SELW  = 1,
  parameter int unsigned NREGS = 2
) (
  input  logic [SELW-1:0]  sel,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      onehot[i] = en && (sel == SELW'(i));
    end
  end

endmodule

// File: rtl/deser_frame_ctrl.sv
// Clocked FSM that fills a bank of capture registers word by word and
// presents the completed frame downstream, with zero-bubble frame restart.
module deser_frame_ctrl
  import deser_pkg::*;
#(
  parameter int unsigned NREGS = 2
) (
  input  logic                clk,
  input  logic                reset,
  deser_frame_ctrl_if.master  bus
);

  localparam int unsigned SELW = sel_width(NREGS);
  localparam int unsigned LENW = len_width(NREGS);

  deser_state_t    state_q;
  logic [SELW-1:0] count_q;
  logic [LENW-1:0] frame_len_q;

  logic [LENW-1:0]  eff_len;
  logic             recv_rdy;
  logic             send_val;
  logic             recv_fire;
  logic             send_fire;
  logic             last_word;
  deser_state_t     start_state;
  logic [SELW-1:0]  start_count;
  logic [NREGS-1:0] wr_en;

  onehot_dec #(
    .SELW  (SELW),
    .NREGS (NREGS)
  ) u_dec (
    .sel    (count_q),
    .en     (recv_fire),
    .onehot (wr_en)
  );

  always_comb begin
    eff_len = bus.cfg_len;
    if (bus.cfg_len == '0 || bus.cfg_len > LENW'(NREGS)) begin
      eff_len = LENW'(NREGS);
    end

    // Single-word frames go straight to SEND, where count must already be 0.
    start_state = (eff_len == LENW'(1)) ? SEND : RECV;
    start_count = (eff_len == LENW'(1)) ? '0 : SELW'(1);
    last_word   = (LENW'(count_q) == frame_len_q - LENW'(1));

    // Outputs are gated by reset so the bank sees nothing while it is held.
    send_val = !reset && (state_q == SEND);
    recv_rdy = !reset && ((state_q == IDLE) || (state_q == RECV) ||
                          (state_q == SEND && bus.send_rdy));
    recv_fire = bus.recv_val && recv_rdy;
    send_fire = send_val && bus.send_rdy;

    bus.recv_rdy  = recv_rdy;
    bus.send_val  = send_val;
    bus.wr_en     = wr_en;
    bus.wr_sel    = reset ? '0 : count_q;
    bus.frame_len = reset ? '0 : frame_len_q;
    bus.busy      = !reset && (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      frame_len_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (recv_fire) begin
            frame_len_q <= eff_len;
            count_q     <= start_count;
            state_q     <= start_state;
          end
        end
        RECV: begin
          if (recv_fire) begin
            if (last_word) begin
              count_q <= '0;
              state_q <= SEND;
            end else begin
              count_q <= count_q + SELW'(1);
            end
          end
        end
        SEND: begin
          if (send_fire) begin
            if (recv_fire) begin
              frame_len_q <= eff_len;
              count_q     <= start_count;
              state_q     <= start_state;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Directed bench for deser_frame_ctrl with a four-register bank.
module tb_deser_frame_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  deser_frame_ctrl_if #(.NREGS(4)) bus ();

  deser_frame_ctrl #(.NREGS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] we, input logic [1:0] ws,
                            input logic rr, input logic sv, input logic bz,
                            input logic [2:0] fl);
    check({tag, ".wr_en"},     {28'd0, bus.wr_en},     {28'd0, we});
    check({tag, ".wr_sel"},    {30'd0, bus.wr_sel},    {30'd0, ws});
    check({tag, ".recv_rdy"},  {31'd0, bus.recv_rdy},  {31'd0, rr});
    check({tag, ".send_val"},  {31'd0, bus.send_val},  {31'd0, sv});
    check({tag, ".busy"},      {31'd0, bus.busy},      {31'd0, bz});
    check({tag, ".frame_len"}, {29'd0, bus.frame_len}, {29'd0, fl});
  endtask

  task automatic drive(input logic rv, input logic sr, input logic [2:0] cl);
    bus.recv_val = rv;
    bus.send_rdy = sr;
    bus.cfg_len  = cl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 3'd4);
    tick();
    tick();
    expect_out("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0);
    expect_out("rst_idle", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();

    // Four words back to back, frame taken immediately.
    drive(1'b1, 1'b1, 3'd4);
    expect_out("t1_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    expect_out("t1_w1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    expect_out("t1_w2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    expect_out("t1_w3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    drive(1'b0, 1'b1, 3'd4);
    expect_out("t1_send", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 3'd4);
    tick();
    expect_out("t1_idle", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);

    // Two-word frame with downstream back-pressure; cfg_len change mid-frame ignored.
    drive(1'b1, 1'b1, 3'd2);
    expect_out("t2_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);
    tick();
    drive(1'b1, 1'b1, 3'd3);
    expect_out("t2_w1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 3'd3);
      expect_out("t2_hold", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 3'd2);
      tick();
    end
    drive(1'b0, 1'b1, 3'd2);
    expect_out("t2_send", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 3'd2);
    tick();
    expect_out("t2_idle", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 3'd2);

    // Zero-bubble streaming of two-word frames.
    drive(1'b1, 1'b1, 3'd2);
    expect_out("t3_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_out("t3_w1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd2);
      tick();
      expect_out("t3_restart", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1, 3'd2);
      tick();
    end
    expect_out("t3_w1_last", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd2);
    tick();
    drive(1'b0, 1'b1, 3'd2);
    expect_out("t3_send", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 3'd2);
    tick();

    // Length clamp: cfg_len 0 then 7 both mean four words; includes a stall in RECV.
    drive(1'b1, 1'b1, 3'd0);
    expect_out("t4a_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    drive(1'b0, 1'b1, 3'd0);
    expect_out("t4a_stall", 4'b0000, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    drive(1'b1, 1'b1, 3'd0);
    expect_out("t4a_w1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    expect_out("t4a_w2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    expect_out("t4a_w3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    drive(1'b0, 1'b1, 3'd0);
    expect_out("t4a_send", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 3'd4);
    tick();
    drive(1'b1, 1'b1, 3'd7);
    expect_out("t4b_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);
    tick();
    expect_out("t4b_w1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    expect_out("t4b_w2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    expect_out("t4b_w3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    drive(1'b0, 1'b1, 3'd7);
    expect_out("t4b_send", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 3'd4);
    tick();

    // Single-word frames.
    drive(1'b1, 1'b1, 3'd1);
    expect_out("t5_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);
    tick();
    expect_out("t5_restart", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1, 3'd1);
    tick();
    drive(1'b0, 1'b1, 3'd1);
    expect_out("t5_send", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 3'd1);
    tick();
    expect_out("t5_idle", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 3'd1);

    // Reset after two of four words drops the partial frame.
    drive(1'b1, 1'b1, 3'd4);
    expect_out("t6_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd1);
    tick();
    expect_out("t6_w1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 3'd4);
    expect_out("t6_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b1, 3'd4);
    expect_out("t6_post_w0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    expect_out("t6_post_w1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    drive(1'b0, 1'b0, 3'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
